host_decoupled_bridge: RTL and testbench

HOST_DECOUPLED_BRIDGE -- requirements
Module: host_decoupled_bridge

---
 rtl/host_decoupled_bridge.sv | 133 +++++++++++++
 tb/tb_host_decoupled_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/host_decoupled_bridge.sv
// Host-to-stream bridge: a toggle-signalled host request is synchronised, its
// payload queued in a small FIFO, and the FIFO head is offered on a
// valid/ready port. Host-side counters and a sticky overflow flag report
// progress back to the host.
module host_decoupled_bridge #(
    parameter int unsigned NWORDS = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   host_req_toggle,
    input  logic [16*NWORDS-1:0]   host_words,
    output logic [15:0]            host_ack_count,
    output logic [15:0]            host_done_count,
    output logic                   host_full,
    output logic                   host_overflow,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [16*NWORDS-1:0]   deq_bits
);

    localparam int unsigned PW = 16 * NWORDS;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s3_q, s3_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   ack_q, ack_d;
    logic [15:0]   done_q, done_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] mem_q [DEPTH];

    logic req_c;
    logic fire_c;
    logic accept_c;
    logic wr_en_c;

    // Next-state logic: request detection, FIFO bookkeeping, registered head.
    always_comb begin
        req_c    = s2_q ^ s3_q;
        fire_c   = valid_q & deq_ready;
        accept_c = req_c & ((count_q < CW'(DEPTH)) | fire_c);
        wr_en_c  = accept_c & ~reset;

        s1_d    = host_req_toggle;
        s2_d    = s1_q;
        s3_d    = s2_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = valid_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        ack_d   = ack_q;
        done_d  = done_q;
        head_d  = head_q;

        if (accept_c) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (fire_c) begin
            rptr_d = rptr_q + AW'(1);
        end
        count_d = count_q + CW'(accept_c) - CW'(fire_c);
        valid_d = (count_d != '0);
        full_d  = (count_d == CW'(DEPTH));
        ovf_d   = ovf_q | (req_c & ~accept_c);
        ack_d   = ack_q + 16'(accept_c);
        done_d  = done_q + 16'(fire_c);

        // The incoming payload becomes the head when nothing else remains queued.
        if (accept_c && (count_q == CW'(fire_c))) begin
            head_d = host_words;
        end else begin
            head_d = mem_q[rptr_d];
        end

        // Reset pre-loads the synchroniser with the current level so no
        // spurious request appears on release.
        if (reset) begin
            s1_d    = host_req_toggle;
            s2_d    = host_req_toggle;
            s3_d    = host_req_toggle;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
            ack_d   = '0;
            done_d  = '0;
            head_d  = '0;
        end
    end

    // State register; reset is folded into the next-state logic above.
    always_ff @(posedge clock) begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        s3_q    <= s3_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
        valid_q <= valid_d;
        full_q  <= full_d;
        ovf_q   <= ovf_d;
        ack_q   <= ack_d;
        done_q  <= done_d;
        head_q  <= head_d;
    end

    // Payload storage, written at the edge that ends the detection cycle.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem_q[wptr_q] <= host_words;
        end
    end

    assign host_ack_count  = ack_q;
    assign host_done_count = done_q;
    assign host_full       = full_q;
    assign host_overflow   = ovf_q;
    assign deq_valid       = valid_q;
    assign deq_bits        = head_q;

endmodule

// File: tb/tb_host_decoupled_bridge.sv
// Scoreboard bench for host_decoupled_bridge: a queue-based model tracks
// accepted payloads, a negedge monitor checks every output against it.
module tb_host_decoupled_bridge;

    localparam int unsigned NWORDS = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PW     = 16 * NWORDS;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          host_req_toggle = 1'b0;
    logic [PW-1:0] host_words = '0;
    logic          deq_ready = 1'b0;
    logic [15:0]   host_ack_count;
    logic [15:0]   host_done_count;
    logic          host_full;
    logic          host_overflow;
    logic          deq_valid;
    logic [PW-1:0] deq_bits;

    host_decoupled_bridge #(.NWORDS(NWORDS), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .host_req_toggle (host_req_toggle),
        .host_words      (host_words),
        .host_ack_count  (host_ack_count),
        .host_done_count (host_done_count),
        .host_full       (host_full),
        .host_overflow   (host_overflow),
        .deq_valid       (deq_valid),
        .deq_ready       (deq_ready),
        .deq_bits        (deq_bits)
    );

    always #5 clock = ~clock;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [PW-1:0] sb_q[$];
    logic [15:0]   ack_m  = '0;
    logic [15:0]   done_m = '0;
    logic          ovf_m  = 1'b0;
    logic          h1, h2, h3;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a request is seen two edges after the toggle is first sampled;
    // it is accepted if the queue (after any pop this cycle) has room.
    initial forever begin
        @(posedge clock);
        if (reset) begin
            sb_q.delete();
            ack_m = '0;
            ovf_m = 1'b0;
            h1 = host_req_toggle;
            h2 = host_req_toggle;
            h3 = host_req_toggle;
        end else begin
            if (h2 !== h3) begin
                if (sb_q.size() < int'(DEPTH)) begin
                    sb_q.push_back(host_words);
                    ack_m++;
                end else begin
                    ovf_m = 1'b1;
                end
            end
            h3 = h2;
            h2 = h1;
            h1 = host_req_toggle;
        end
    end

    // Monitor: compare outputs each cycle, pop the scoreboard on each fire.
    initial forever begin
        @(negedge clock);
        if (mon_en) begin
            check("deq_valid", 64'(deq_valid), 64'(sb_q.size() != 0));
            if (sb_q.size() != 0) check("deq_bits", 64'(deq_bits), 64'(sb_q[0]));
            check("host_full", 64'(host_full), 64'(sb_q.size() == int'(DEPTH)));
            check("host_overflow", 64'(host_overflow), 64'(ovf_m));
            check("host_ack_count", 64'(host_ack_count), 64'(ack_m));
            check("host_done_count", 64'(host_done_count), 64'(done_m));
            if (reset) begin
                done_m = '0;
            end else if (sb_q.size() != 0 && deq_ready) begin
                void'(sb_q.pop_front());
                done_m++;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Host protocol: words stable 3 cycles ahead, then toggle, then wait for write.
    task automatic send(input logic [PW-1:0] w);
        host_words = w;
        step(3);
        host_req_toggle = ~host_req_toggle;
        step(4);
    endtask

    initial begin
        // Reset with toggle high; no request on release.
        reset = 1'b1;
        host_req_toggle = 1'b1;
        step(1);
        mon_en = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        check("idle_valid", 64'(deq_valid), 64'd0);
        check("idle_ack", 64'(host_ack_count), 64'd0);

        // Single payload latency.
        host_req_toggle = 1'b0;
        do_reset();
        deq_ready = 1'b1;
        host_words = {16'h0003, 16'h0002, 16'h0001};
        step(3);
        host_req_toggle = 1'b1;
        step(2);
        check("lat_valid_early", 64'(deq_valid), 64'd0);
        step(1);
        check("lat_valid", 64'(deq_valid), 64'd1);
        check("lat_bits", 64'(deq_bits), 64'h0000_0003_0002_0001);
        check("lat_ack", 64'(host_ack_count), 64'd1);
        step(1);
        check("lat_done", 64'(host_done_count), 64'd1);

        // Fill past capacity, then drain in order.
        do_reset();
        deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(PW'(32'h10 + 32'(i)));
        check("ovf_full", 64'(host_full), 64'd1);
        check("ovf_ack", 64'(host_ack_count), 64'd4);
        check("ovf_flag", 64'(host_overflow), 64'd1);
        deq_ready = 1'b1;
        step(8);
        check("ovf_done", 64'(host_done_count), 64'd4);
        check("ovf_drained", 64'(deq_valid), 64'd0);
        check("ovf_sticky", 64'(host_overflow), 64'd1);

        // Full FIFO, request detected in the same cycle as a fire.
        do_reset();
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(PW'(32'h20 + 32'(i)));
        check("sim_full_pre", 64'(host_full), 64'd1);
        host_words = PW'(32'h99);
        step(3);
        host_req_toggle = ~host_req_toggle;
        step(2);
        deq_ready = 1'b1;
        step(1);
        deq_ready = 1'b0;
        check("sim_ack", 64'(host_ack_count), 64'(DEPTH + 1));
        check("sim_ovf", 64'(host_overflow), 64'd0);
        check("sim_full", 64'(host_full), 64'd1);
        deq_ready = 1'b1;
        step(8);
        check("sim_done", 64'(host_done_count), 64'(DEPTH + 1));

        // Reset mid-operation with entries queued and ready toggling.
        do_reset();
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(PW'(32'h30 + 32'(i)));
        for (int i = 0; i < 3; i++) begin
            deq_ready = ~deq_ready;
            step(1);
        end
        reset = 1'b1;
        deq_ready = ~deq_ready;
        step(1);
        reset = 1'b0;
        check("mid_valid", 64'(deq_valid), 64'd0);
        check("mid_full", 64'(host_full), 64'd0);
        check("mid_ovf", 64'(host_overflow), 64'd0);
        check("mid_ack", 64'(host_ack_count), 64'd0);
        check("mid_done", 64'(host_done_count), 64'd0);
        check("mid_bits", 64'(deq_bits), 64'd0);
        for (int i = 0; i < 6; i++) begin
            deq_ready = ~deq_ready;
            step(1);
            check("mid_no_fire", 64'(host_done_count), 64'd0);
        end

        // Randomised traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            deq_ready  = ($urandom_range(0, 3) != 0);
            host_words = PW'({$urandom(), $urandom()});
            if ($urandom_range(0, 2) == 0) host_req_toggle = ~host_req_toggle;
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        deq_ready = 1'b1;
        step(12);

        // Counter wrap: 65537 back-to-back accepted and fired payloads.
        do_reset();
        deq_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            host_words = PW'(i);
            host_req_toggle = ~host_req_toggle;
            step(1);
        end
        step(10);
        check("wrap_ack", 64'(host_ack_count), 64'd1);
        check("wrap_done", 64'(host_done_count), 64'd1);
        check("wrap_ovf", 64'(host_overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
